// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared funct3 codes, FSM state encoding and store-lane helpers
//               for the MEM-stage load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Stores only know SB/SH; the unsigned load codes fall through to word.
  function automatic size_t access_size(input logic [2:0] f3, input logic is_store);
    size_t sz;
    sz = SZ_WORD;
    if (f3 == F3_B || (!is_store && f3 == F3_BU))
      sz = SZ_BYTE;
    else if (f3 == F3_H || (!is_store && f3 == F3_HU))
      sz = SZ_HALF;
    return sz;
  endfunction

  function automatic logic [3:0] store_be(input size_t sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input size_t sz, input logic [31:0] data);
    logic [31:0] wd;
    case (sz)
      SZ_BYTE: wd = {4{data[7:0]}};
      SZ_HALF: wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
    return ((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Data-memory req/ack bus between the load/store unit (master)
//               and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_load_formatter.sv
`default_nettype none
// ============================================================================
// Module      : load_formatter
// Description : Extracts the addressed byte/halfword/word from a read beat and
//               sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    // Halfword lane ignores addr[0]; an odd offset is either trapped upstream or tolerated.
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h000000, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store unit with req/ack data-memory handshake,
//               timeout and optional misalignment trap (MEM_MISALIGN_TRAP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        ALUresult_MEM,
  input  logic [31:0]        data2_MEM,
  input  logic               MemRead_MEM,
  input  logic               MemWrite_MEM,
  input  logic [2:0]         funct3_MEM,
  mem_access_unit_if.master  dmem,
  output logic               stall_MEM,
  output logic [31:0]        load_data_MEM,
  output logic               bus_err_MEM,
  output logic               misalign_MEM
);

  localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_count;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_load_data;
  logic        r_bus_err;
  logic        r_misalign;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_funct3;

  logic        w_acc;
  logic        w_is_store;
  size_t       w_size;
  logic        w_trap;
  logic        w_timeout;
  logic [31:0] w_load_fmt;

  assign w_acc      = MemRead_MEM | MemWrite_MEM;
  assign w_is_store = MemWrite_MEM;
  assign w_size     = access_size(funct3_MEM, w_is_store);
  assign w_timeout  = (r_count == c_TIMEOUT_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = is_misaligned(w_size, ALUresult_MEM[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  load_formatter u_load_fmt (
    .i_rdata   (dmem.rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_load_fmt)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // DONE always drops stall so the held instruction retires exactly once.
  always_comb begin
    w_next_state = r_state;
    stall_MEM    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          stall_MEM    = 1'b1;
          w_next_state = w_trap ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        stall_MEM = 1'b1;
        if (dmem.ack || w_timeout) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_be        <= 4'h0;
      r_load_data <= 32'h0;
      r_bus_err   <= 1'b0;
      r_misalign  <= 1'b0;
      r_count     <= 8'h0;
      r_addr_lo   <= 2'b00;
      r_funct3    <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_count <= 8'h0;
            if (w_trap) begin
              r_misalign  <= 1'b1;
              r_load_data <= 32'h0;
            end else begin
              r_req     <= 1'b1;
              r_we      <= w_is_store;
              r_addr    <= {ALUresult_MEM[31:2], 2'b00};
              r_be      <= w_is_store ? store_be(w_size, ALUresult_MEM[1:0]) : 4'b0000;
              r_wdata   <= store_wdata(w_size, data2_MEM);
              r_addr_lo <= ALUresult_MEM[1:0];
              r_funct3  <= funct3_MEM;
            end
          end
        end
        S_REQ: begin
          r_count <= r_count + 8'd1;
          if (dmem.ack) begin
            r_req <= 1'b0;
            if (!r_we) r_load_data <= w_load_fmt;
          end else if (w_timeout) begin
            r_req       <= 1'b0;
            r_bus_err   <= 1'b1;
            r_load_data <= 32'h0;
          end
        end
        S_DONE: begin
          r_bus_err  <= 1'b0;
          r_misalign <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dmem.req      = r_req;
  assign dmem.we       = r_we;
  assign dmem.addr     = r_addr;
  assign dmem.wdata    = r_wdata;
  assign dmem.be       = r_be;
  assign load_data_MEM = r_load_data;
  assign bus_err_MEM   = r_bus_err;
  assign misalign_MEM  = r_misalign;

endmodule
`default_nettype wire
